register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; legal values are 2..256.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 makes register 0 read as zero and ignore writes.
REQ-004 SHALL have parameter BYPASS, default 1; 1 gives write-to-read forwarding in the same cycle.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port waddr, input, AW = $clog2(DEPTH), write address.
REQ-009 SHALL have port wdata, input, WIDTH, write data.
REQ-010 SHALL have port wstrb, input, WIDTH/8, byte-lane write strobes; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port raddr1, input, AW, read port 1 address.
REQ-012 SHALL have port rdata1, output, WIDTH, read port 1 data.
REQ-013 SHALL have port raddr2, input, AW, read port 2 address.
REQ-014 SHALL have port rdata2, output, WIDTH, read port 2 data.

Function
REQ-015 Write: on a rising clk edge with we=1 and rst=1, each byte lane of register[waddr] with wstrb[i]=1 SHALL take wdata lane i; lanes with wstrb[i]=0 SHALL hold.
REQ-016 we=0 or wstrb all-zero SHALL leave every register unchanged.
REQ-017 waddr >= DEPTH (non-power-of-two DEPTH) SHALL be ignored; no register changes.
REQ-018 ZERO_REG=1: writes to address 0 SHALL be discarded; rdataN for raddrN=0 SHALL be 0 regardless of BYPASS.
REQ-019 Reads SHALL be combinational: rdataN = register[raddrN] with zero cycles of latency.
REQ-020 raddrN >= DEPTH SHALL return 0.
REQ-021 BYPASS=1 and a write pending this cycle to raddrN: rdataN SHALL show the byte-merged post-write value (strobed lanes from wdata, others from stored value) in the same cycle.
REQ-022 BYPASS=0: rdataN SHALL show the stored pre-write value until the edge, then the new value.
REQ-023 Both read ports SHALL work independently, including both reading the write target.

Reset
REQ-024 rst=0 SHALL clear every register to 0 immediately, independent of clk.
REQ-025 While rst=0, writes SHALL be ignored and rdata1/rdata2 SHALL read 0, bypass included.
REQ-026 Reset asserted mid-write SHALL win; the register holds 0 after rst deasserts.
REQ-027 The first write after rst rises SHALL take effect on the first rising clk edge that sees rst=1.

Structure
REQ-028 Shared package rf_pkg SHALL hold default WIDTH/DEPTH constants, the byte-lane width constant (8) and a function computing AW.
REQ-029 One sub-module, register_cell (WIDTH, async active-low clear, per-byte enable), SHALL be instantiated DEPTH times via generate; address decode, bypass and read muxes stay in register_file.
REQ-030 Parameter legality (WIDTH%8, DEPTH range) SHALL be checked at elaboration with a fatal error.

Verification
REQ-031 Reset: rst=0 mid-run with registers loaded -> all rdataN read 0 at once; after rst=1 every address reads 0.
REQ-032 Full write: we=1, waddr=5, wdata=32'hDEADBEEF, wstrb=4'hF; next cycle raddr1=5 -> rdata1=32'hDEADBEEF.
REQ-033 Byte strobes: reg 7 = 32'h11223344; write wdata=32'hAABBCCDD, wstrb=4'b0101 -> reg 7 = 32'h11BB33DD.
REQ-034 Zero register: write 32'hFFFFFFFF to address 0 -> rdata1 with raddr1=0 reads 0 before and after the edge.
REQ-035 Bypass: BYPASS=1, reg 3 = 10, write 20 to reg 3 with raddr1=raddr2=3 -> both read 20 in the write cycle; BYPASS=0 -> 10 in the write cycle, 20 after the edge.
REQ-036 Enable hold: we=0, waddr=9, wdata=554 for 3 cycles -> reg 9 keeps its prior value 53.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// rf_pkg
//   Shared constants and helpers for the register file.
//   Revision: 1.0
// ============================================================================
package rf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int LANE_W    = 8;

  // Address width; never below one bit so a two-entry file still has a port.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_cell.sv
`default_nettype none
// ============================================================================
// register_cell
//   One register with per-byte load enables and asynchronous active-low clear.
//   Revision: 1.0
// ============================================================================
module register_cell
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH/LANE_W-1:0]  be,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q
);

  localparam int c_nb = WIDTH / LANE_W;

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < c_nb; i++) begin
        if (be[i]) r_q[i*LANE_W +: LANE_W] <= d[i*LANE_W +: LANE_W];
      end
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// register_file
//   Two-read / one-write register file with byte strobes and write forwarding.
//   Revision: 1.0
// ============================================================================
module register_file
  import rf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(DEPTH),
  localparam int NB      = WIDTH / LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wstrb,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2
);

  localparam int         c_slots = 2 ** AW;
  localparam logic [AW:0] c_depth = DEPTH[AW:0];

  if ((WIDTH % LANE_W) != 0 || WIDTH < LANE_W || DEPTH < 2 || DEPTH > 256) begin : g_bad_params
    $fatal(1, "register_file: illegal WIDTH=%0d / DEPTH=%0d", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0] w_regs [c_slots];
  logic             w_wr_valid;

  // Out-of-range and (optionally) zero-register writes never reach a cell,
  // which also keeps them out of the forwarding path.
  assign w_wr_valid = rst && we && ({1'b0, waddr} < c_depth)
                      && !((ZERO_REG != 0) && (waddr == '0));

  for (genvar i = 0; i < c_slots; i++) begin : g_slot
    if (i < DEPTH) begin : g_cell
      logic [NB-1:0] w_be;
      assign w_be = (w_wr_valid && (waddr == AW'(i))) ? wstrb : '0;

      register_cell #(.WIDTH(WIDTH)) u_cell (
        .clk (clk),
        .rst (rst),
        .be  (w_be),
        .d   (wdata),
        .q   (w_regs[i])
      );
    end else begin : g_pad
      assign w_regs[i] = '0;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr,
                                                 input logic [WIDTH-1:0] stored);
    logic [WIDTH-1:0] v;
    v = stored;
    if ((BYPASS != 0) && w_wr_valid && (waddr == addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) v[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
      end
    end
    return rst ? v : '0;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1, w_regs[raddr1]);
    rdata2 = read_port(raddr2, w_regs[raddr2]);
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// tb_register_file
//   Directed bench: default instance plus a BYPASS=0, DEPTH=12, ZERO_REG=0 one.
//   Revision: 1.0
// ============================================================================
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic [3:0]  wstrb;
  logic        nb_we;
  logic [3:0]  nb_waddr, nb_raddr1, nb_raddr2;
  logic [31:0] nb_wdata, nb_rdata1, nb_rdata2;
  logic [3:0]  nb_wstrb;
  int          checks;
  int          errors;

  register_file dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
  );

  register_file #(.DEPTH(12), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata),
    .wstrb(nb_wstrb), .raddr1(nb_raddr1), .rdata1(nb_rdata1),
    .raddr2(nb_raddr2), .rdata2(nb_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    we = 1'b0;
  endtask

  task automatic wr_nb(input logic [3:0] a, input logic [31:0] d);
    nb_we = 1'b1; nb_waddr = a; nb_wdata = d; nb_wstrb = 4'hF;
    tick();
    nb_we = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr1 = '0; raddr2 = '0;
    nb_we = 1'b0; nb_waddr = '0; nb_wdata = '0; nb_wstrb = '0;
    nb_raddr1 = '0; nb_raddr2 = '0;
    #2 rst = 1'b0;
    raddr1 = 5'd4;
    #10;
    check("reset_rd", rdata1, 32'h0);
    tick();
    rst = 1'b1;

    wr(5'd5, 32'hDEADBEEF, 4'hF);
    raddr1 = 5'd5; #1;
    check("full_write", rdata1, 32'hDEADBEEF);

    wr(5'd7, 32'h11223344, 4'hF);
    wr(5'd7, 32'hAABBCCDD, 4'b0101);
    raddr2 = 5'd7; #1;
    check("byte_strobe", rdata2, 32'h11BB33DD);

    raddr1 = 5'd0; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; #1;
    check("zero_pre", rdata1, 32'h0);
    tick(); we = 1'b0; #1;
    check("zero_post", rdata1, 32'h0);

    wr(5'd3, 32'd10, 4'hF);
    raddr1 = 5'd3; raddr2 = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'd20; wstrb = 4'hF; #1;
    check("byp_rd1", rdata1, 32'd20);
    check("byp_rd2", rdata2, 32'd20);
    tick(); we = 1'b0; #1;
    check("byp_after", rdata1, 32'd20);

    raddr1 = 5'd5; we = 1'b1; waddr = 5'd5; wdata = 32'h00000012; wstrb = 4'b0001; #1;
    check("byp_merge", rdata1, 32'hDEADBE12);
    wstrb = 4'b0000; #1;
    check("byp_nostrb", rdata1, 32'hDEADBEEF);
    we = 1'b0;

    wr_nb(4'd3, 32'd10);
    nb_raddr1 = 4'd3; nb_raddr2 = 4'd3;
    nb_we = 1'b1; nb_waddr = 4'd3; nb_wdata = 32'd20; nb_wstrb = 4'hF; #1;
    check("nbyp_rd1", nb_rdata1, 32'd10);
    check("nbyp_rd2", nb_rdata2, 32'd10);
    tick(); nb_we = 1'b0; #1;
    check("nbyp_after1", nb_rdata1, 32'd20);
    check("nbyp_after2", nb_rdata2, 32'd20);

    wr(5'd9, 32'd53, 4'hF);
    raddr1 = 5'd9; we = 1'b0; waddr = 5'd9; wdata = 32'd554; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    check("hold_we0", rdata1, 32'd53);
    we = 1'b1; wstrb = 4'h0;
    tick(); we = 1'b0; #1;
    check("hold_strb0", rdata1, 32'd53);

    wr_nb(4'd0, 32'h000000AB);
    wr_nb(4'd5, 32'h00000055);
    nb_raddr1 = 4'd0; #1;
    check("nozero_reg0", nb_rdata1, 32'h000000AB);
    nb_raddr1 = 4'd13; nb_raddr2 = 4'd5;
    nb_we = 1'b1; nb_waddr = 4'd13; nb_wdata = 32'hFFFFFFFF; nb_wstrb = 4'hF;
    tick(); nb_we = 1'b0; #1;
    check("oor_read", nb_rdata1, 32'h0);
    check("oor_noalias", nb_rdata2, 32'h00000055);

    raddr1 = 5'd5; raddr2 = 5'd3;
    we = 1'b1; waddr = 5'd5; wdata = 32'h1; wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst_async1", rdata1, 32'h0);
    check("rst_async2", rdata2, 32'h0);
    tick(); #1;
    check("rst_wr_ign", rdata1, 32'h0);
    we = 1'b0; rst = 1'b1; #1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); #1;
      check($sformatf("rst_clear_%0d", a), rdata1, 32'h0);
    end
    nb_raddr1 = 4'd5; #1;
    check("nb_rst_clear", nb_rdata1, 32'h0);

    wr(5'd5, 32'hCAFEF00D, 4'hF);
    raddr1 = 5'd5; #1;
    check("first_wr", rdata1, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
